// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Purpose:
//   Sequencer for a multicycle RISC-V datapath. A single ALU and a single
//   unified memory port are shared across fetch, decode, execute, memory and
//   writeback steps. The FSM walks each instruction through those steps,
//   stretching the memory steps while mem_ready is low. It also counts
//   retired instructions and traps on unsupported opcodes.
//
// Ports:
//   clk          in   system clock, rising edge active
//   reset        in   asynchronous, active-low reset
//   opcode[6:0]  in   instruction[6:0] from the instruction register
//   zero         in   ALU zero flag (consumed by the datapath's PC qualifier)
//   mem_ready    in   memory access completes this cycle
//   PCWrite      out  unconditional PC load
//   PCWriteCond  out  PC load qualified externally by zero
//   PCSource     out  PC input select: 0 = ALU result, 1 = ALUOut
//   IorD         out  memory address select: 0 = PC, 1 = ALUOut
//   MemRead      out  memory read strobe
//   MemWrite     out  memory write strobe
//   IRWrite      out  load instruction register and OldPC
//   MemToReg     out  writeback select: 1 = memory data, 0 = ALUOut
//   RegWrite     out  register file write enable
//   ALUSrcA[1:0] out  00 = PC, 01 = rs1, 10 = OldPC
//   ALUSrcB[1:0] out  00 = rs2, 01 = constant 1, 10 = imm
//   ALUOp[1:0]   out  00 = add, 01 = sub, 10 = R-type funct, 11 = I-type funct
//   state[3:0]   out  current state encoding (debug)
//   illegal      out  sticky: unsupported opcode decoded
//   instr_count  out  retired-instruction counter, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             PCSource,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        EXEC_I    = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        TRAP      = 4'd10
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;

    // The branch decision is made in the datapath (PCWriteCond & zero), so
    // the sequencer itself never looks at the flag.
    logic zero_unused;
    assign zero_unused = zero;

    // State, sticky trap flag and retirement counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    // Next-state logic, including the wait states on the memory steps.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            FETCH: begin
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_R:               state_d = EXEC_R;
                    OP_I:               state_d = EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = MEM_ADDR;
                    OP_BRANCH:          state_d = BRANCH;
                    default:            state_d = TRAP;
                endcase
            end
            MEM_ADDR: begin
                state_d = (opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                if (mem_ready) state_d = MEM_WB;
            end
            MEM_WB: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            MEM_WRITE: begin
                if (mem_ready) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            EXEC_R:  state_d = ALU_WB;
            EXEC_I:  state_d = ALU_WB;
            ALU_WB: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            BRANCH: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    // Counter and trap flag updates; the trapping instruction never retires
    // because TRAP has no exit.
    always_comb begin
        count_d   = retire ? count_q + 1'b1 : count_q;
        illegal_d = illegal_q | (state_q == DECODE && state_d == TRAP);
    end

    // Control decode of the current state. Reset low overrides everything
    // combinationally so the datapath is quiet even mid-instruction.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b10;
            end
            MEM_ADDR: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
            end
            MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXEC_R: begin
                ALUSrcA = 2'b01;
                ALUOp   = 2'b10;
            end
            EXEC_I: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
            end
            ALU_WB: begin
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 2'b01;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
            end
            default: begin
            end
        endcase
        if (!reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            PCSource    = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemToReg    = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 2'b00;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
        end
    end

    assign state       = state_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Purpose:
//   Self-checking bench for multicycle_control. Each instruction is described
//   by its class plus wait counts; the bench expands that into the expected
//   per-cycle state walk and the control table for each step, then drives
//   mem_ready cycle by cycle and compares. Retirements are counted by the
//   bench independently of the design.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_READ = 3,
                   S_MEM_WB = 4, S_MEM_WRITE = 5, S_EXEC_R = 6, S_EXEC_I = 7,
                   S_ALU_WB = 8, S_BRANCH = 9, S_TRAP = 10;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011,
                           OP_L = 7'b0000011, OP_S = 7'b0100011,
                           OP_B = 7'b1100011, OP_BAD = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite;
    logic        IRWrite, MemToReg, RegWrite;
    logic [1:0]  ALUSrcA, ALUSrcB, ALUOp;
    logic [3:0]  state;
    logic        illegal;
    logic [31:0] instr_count;

    int          total = 0;
    int          bad = 0;
    logic [31:0] model_count = 0;

    typedef struct {
        int st;
        bit mr;
    } step_t;

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .PCSource(PCSource), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .state(state), .illegal(illegal),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    wire [14:0] ctrl = {PCWrite, PCWriteCond, PCSource, IorD, MemRead,
                        MemWrite, IRWrite, MemToReg, RegWrite,
                        ALUSrcA, ALUSrcB, ALUOp};

    // Control table per step, packed in the same order as ctrl.
    function automatic logic [14:0] exp_ctrl(input int st, input bit mr);
        logic pcw, pcc, pcs, iord, mrd, mwr, irw, m2r, rw;
        logic [1:0] a, b, op;
        {pcw, pcc, pcs, iord, mrd, mwr, irw, m2r, rw} = '0;
        a = 2'b00; b = 2'b00; op = 2'b00;
        case (st)
            S_FETCH:     begin mrd = 1; b = 2'b01; irw = mr; pcw = mr; end
            S_DECODE:    begin a = 2'b10; b = 2'b10; end
            S_MEM_ADDR:  begin a = 2'b01; b = 2'b10; end
            S_MEM_READ:  begin mrd = 1; iord = 1; end
            S_MEM_WB:    begin rw = 1; m2r = 1; end
            S_MEM_WRITE: begin mwr = 1; iord = 1; end
            S_EXEC_R:    begin a = 2'b01; op = 2'b10; end
            S_EXEC_I:    begin a = 2'b01; b = 2'b10; op = 2'b11; end
            S_ALU_WB:    begin rw = 1; end
            S_BRANCH:    begin a = 2'b01; op = 2'b01; pcc = 1; pcs = 1; end
            default:     begin end
        endcase
        return {pcw, pcc, pcs, iord, mrd, mwr, irw, m2r, rw, a, b, op};
    endfunction

    // Expand one instruction into its step list and walk the design through
    // it, comparing every cycle. fw/mw are the wait cycles in FETCH and in
    // the data memory step.
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                             input int zr, input string name);
        step_t q[$];
        logic [14:0] want;
        q = {};
        for (int i = 0; i < fw; i++) q.push_back('{S_FETCH, 1'b0});
        q.push_back('{S_FETCH, 1'b1});
        q.push_back('{S_DECODE, 1'($urandom_range(0, 1))});
        case (op)
            OP_R: begin
                q.push_back('{S_EXEC_R, 1'($urandom_range(0, 1))});
                q.push_back('{S_ALU_WB, 1'($urandom_range(0, 1))});
            end
            OP_I: begin
                q.push_back('{S_EXEC_I, 1'($urandom_range(0, 1))});
                q.push_back('{S_ALU_WB, 1'($urandom_range(0, 1))});
            end
            OP_B: q.push_back('{S_BRANCH, 1'($urandom_range(0, 1))});
            OP_L: begin
                q.push_back('{S_MEM_ADDR, 1'($urandom_range(0, 1))});
                for (int i = 0; i < mw; i++) q.push_back('{S_MEM_READ, 1'b0});
                q.push_back('{S_MEM_READ, 1'b1});
                q.push_back('{S_MEM_WB, 1'($urandom_range(0, 1))});
            end
            default: begin
                q.push_back('{S_MEM_ADDR, 1'($urandom_range(0, 1))});
                for (int i = 0; i < mw; i++) q.push_back('{S_MEM_WRITE, 1'b0});
                q.push_back('{S_MEM_WRITE, 1'b1});
            end
        endcase
        foreach (q[i]) begin
            @(negedge clk);
            if (i == 0) opcode = op;
            mem_ready = q[i].mr;
            zero = (zr < 0) ? 1'($urandom_range(0, 1)) : 1'(zr);
            #1;
            want = exp_ctrl(q[i].st, q[i].mr);
            total++;
            if (state !== 4'(q[i].st) || ctrl !== want ||
                instr_count !== model_count || illegal !== 1'b0 ||
                (MemRead && MemWrite)) begin
                bad++;
                $display("[TB] FAIL %s step%0d: got state=%0d ctrl=%h cnt=%0d ill=%b, want state=%0d ctrl=%h cnt=%0d ill=0",
                         name, i, state, ctrl, instr_count, illegal,
                         q[i].st, want, model_count);
            end
        end
        model_count++;
    endtask

    // Idle one cycle in FETCH and confirm the retirement count.
    task automatic check_count(input string name);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        total++;
        if (instr_count !== model_count || state !== 4'(S_FETCH)) begin
            bad++;
            $display("[TB] FAIL %s: got cnt=%0d state=%0d, want cnt=%0d state=0",
                     name, instr_count, state, model_count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_ready = 1'b1; opcode = OP_R; zero = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (state !== 4'd0 || ctrl !== 15'd0 || instr_count !== 32'd0 ||
            illegal !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset: got state=%0d ctrl=%h cnt=%0d ill=%b, want 0/0/0/0",
                     state, ctrl, instr_count, illegal);
        end
        mem_ready = 1'b0;
        #1 reset = 1'b1;
        model_count = 0;
        check_count("reset_release");
    endtask

    task automatic test_rtype();
        run_instr(OP_R, 0, 0, -1, "rtype");
        check_count("rtype_count");
    endtask

    task automatic test_load_wait();
        run_instr(OP_L, 0, 2, -1, "load_wait");
        check_count("load_count");
    endtask

    task automatic test_store_fetch_wait();
        run_instr(OP_S, 1, 0, -1, "store_fwait");
        run_instr(OP_S, 0, 3, -1, "store_mwait");
        check_count("store_count");
    endtask

    task automatic test_branch();
        run_instr(OP_B, 0, 0, 0, "branch_z0");
        run_instr(OP_B, 0, 0, 1, "branch_z1");
        check_count("branch_count");
    endtask

    task automatic test_random();
        logic [6:0] ops [5];
        ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_L; ops[3] = OP_S; ops[4] = OP_B;
        for (int n = 0; n < 40; n++)
            run_instr(ops[$urandom_range(0, 4)], $urandom_range(0, 2),
                      $urandom_range(0, 3), -1, "random");
        check_count("random_count");
    endtask

    task automatic test_async_reset();
        opcode = OP_L;
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); mem_ready = 1'b0;
        #1;
        total++;
        if (state !== 4'(S_MEM_READ) || MemRead !== 1'b1) begin
            bad++;
            $display("[TB] FAIL async_setup: got state=%0d MemRead=%b, want 3/1",
                     state, MemRead);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if (state !== 4'd0 || ctrl !== 15'd0 || instr_count !== 32'd0) begin
            bad++;
            $display("[TB] FAIL async_assert: got state=%0d ctrl=%h cnt=%0d, want 0/0/0",
                     state, ctrl, instr_count);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (ctrl !== 15'd0 || state !== 4'd0) begin
            bad++;
            $display("[TB] FAIL async_hold: got state=%0d ctrl=%h, want 0/0",
                     state, ctrl);
        end
        mem_ready = 1'b0;
        #1 reset = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (state !== 4'd0 || ctrl !== exp_ctrl(S_FETCH, 1'b0) ||
            instr_count !== 32'd0) begin
            bad++;
            $display("[TB] FAIL async_release: got state=%0d ctrl=%h cnt=%0d, want 0/%h/0",
                     state, ctrl, instr_count, exp_ctrl(S_FETCH, 1'b0));
        end
        model_count = 0;
    endtask

    task automatic test_trap();
        run_instr(OP_I, 0, 0, -1, "pre_trap");
        @(negedge clk); opcode = OP_BAD; mem_ready = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (state !== 4'(S_DECODE) || illegal !== 1'b0) begin
            bad++;
            $display("[TB] FAIL trap_decode: got state=%0d ill=%b, want 1/0",
                     state, illegal);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            opcode = (i < 10) ? OP_BAD : OP_R;
            #1;
            total++;
            if (state !== 4'(S_TRAP) || ctrl !== 15'd0 || illegal !== 1'b1 ||
                instr_count !== model_count) begin
                bad++;
                $display("[TB] FAIL trap_hold c%0d: got state=%0d ctrl=%h ill=%b cnt=%0d, want 10/0/1/%0d",
                         i, state, ctrl, illegal, instr_count, model_count);
            end
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if (illegal !== 1'b0 || state !== 4'd0) begin
            bad++;
            $display("[TB] FAIL trap_clear: got ill=%b state=%0d, want 0/0",
                     illegal, state);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_store_fetch_wait();
        test_branch();
        test_random();
        test_async_reset();
        test_trap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
